// File: rtl/setup_multislot_if.sv
// rtl/setup_multislot_if.sv - keypad-side bundle: setup request level plus decoded key strobe
interface setup_multislot_if;
  logic       setup_req;
  logic [3:0] key_val;
  logic       key_valid;

  modport master (output setup_req, output key_val, output key_valid);
  modport slave  (input  setup_req, input  key_val, input  key_valid);
endinterface

// File: rtl/setup_multislot.sv
// rtl/setup_multislot.sv - multi-slot password setup FSM: master auth, slot pick, double entry, lockout
module setup_multislot #(
  parameter int N_DIG_MAX  = 12,
  parameter int N_DIG_MIN  = 4,
  parameter int N_SLOTS    = 4,
  parameter logic [4*N_DIG_MAX-1:0] MASTER_PW = 'h1234,
  parameter int MASTER_LEN = 4,
  parameter int MAX_FAIL   = 3,
  parameter int LOCK_CYC   = 5000,
  parameter int IDLE_CYC   = 100000
) (
  input  logic                           clk,
  input  logic                           rst,
  setup_multislot_if.slave               kp,
  output logic                           setup_active,
  output logic                           display_en,
  output logic [23:0]                    bcd_pac,
  output logic [$clog2(N_SLOTS)-1:0]     slot_idx,
  output logic [4*N_DIG_MAX-1:0]         slot_pw,
  output logic [$clog2(N_DIG_MAX+1)-1:0] slot_len,
  output logic                           data_setup_ok,
  output logic                           auth_fail,
  output logic                           locked
);
  localparam int W   = 4 * N_DIG_MAX;
  localparam int IW  = $clog2(N_SLOTS);
  localparam int LW  = $clog2(N_DIG_MAX + 1);
  localparam int FW  = $clog2(MAX_FAIL + 1);
  localparam int TLW = $clog2(LOCK_CYC + 1);
  localparam int TIW = $clog2(IDLE_CYC + 1);

  localparam logic [LW-1:0]  LEN_MAX    = LW'(N_DIG_MAX);
  localparam logic [LW-1:0]  LEN_MIN    = LW'(N_DIG_MIN);
  localparam logic [LW-1:0]  LEN_MASTER = LW'(MASTER_LEN);
  localparam logic [FW-1:0]  FAIL_LAST  = FW'(MAX_FAIL - 1);
  localparam logic [TLW-1:0] LOCK_LAST  = TLW'(LOCK_CYC - 1);
  localparam logic [TIW-1:0] IDLE_LAST  = TIW'(IDLE_CYC - 1);
  // Buffer is F-padded, so the master is compared against its F-padded image
  localparam logic [W-1:0]   M_MASK     = {W{1'b1}} >> (W - 4 * MASTER_LEN);
  localparam logic [W-1:0]   MASTER_FULL = (MASTER_PW & M_MASK) | ~M_MASK;

  typedef enum logic [2:0] {
    S_IDLE, S_AUTH, S_SEL, S_NEW, S_CONFIRM, S_LOCK
  } state_t;

  state_t         state;
  logic [W-1:0]   dig_buf, sh_buf;
  logic [LW-1:0]  dig_len, sh_len;
  logic [FW-1:0]  fail_cnt;
  logic [TLW-1:0] lock_cnt;
  logic [TIW-1:0] idle_cnt;
  logic           req_q;

  logic key_digit, key_star, key_hash, in_session;
  assign key_digit  = kp.key_val <= 4'd9;
  assign key_star   = kp.key_val == 4'hA;
  assign key_hash   = kp.key_val == 4'hB;
  assign in_session = (state == S_AUTH) || (state == S_SEL) ||
                      (state == S_NEW)  || (state == S_CONFIRM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      dig_buf       <= '1;
      dig_len       <= '0;
      sh_buf        <= '1;
      sh_len        <= '0;
      fail_cnt      <= '0;
      lock_cnt      <= '0;
      idle_cnt      <= '0;
      req_q         <= 1'b0;
      slot_idx      <= '0;
      slot_pw       <= '1;
      slot_len      <= '0;
      data_setup_ok <= 1'b0;
      auth_fail     <= 1'b0;
    end else begin
      req_q         <= kp.setup_req;
      data_setup_ok <= 1'b0;
      auth_fail     <= 1'b0;
      // Abort outranks any key in the same cycle, including a confirming '*'
      if (in_session && !kp.setup_req) begin
        state    <= S_IDLE;
        dig_buf  <= '1;
        dig_len  <= '0;
        idle_cnt <= '0;
      end else if (state == S_IDLE) begin
        idle_cnt <= '0;
        if (kp.setup_req && !req_q) begin
          state   <= S_AUTH;
          dig_buf <= '1;
          dig_len <= '0;
        end
      end else if (state == S_LOCK) begin
        if (lock_cnt == LOCK_LAST) begin
          state    <= S_IDLE;
          lock_cnt <= '0;
          fail_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end else if (kp.key_valid) begin
        idle_cnt <= '0;
        if (key_digit) begin
          if (state == S_SEL) begin
            if (int'(kp.key_val) < N_SLOTS) begin
              slot_idx <= kp.key_val[IW-1:0];
              state    <= S_NEW;
              dig_buf  <= '1;
              dig_len  <= '0;
            end
          end else begin
            dig_buf <= {dig_buf[W-5:0], kp.key_val};
            if (dig_len != LEN_MAX) dig_len <= dig_len + 1'b1;
          end
        end else if (key_hash) begin
          state   <= S_IDLE;
          dig_buf <= '1;
          dig_len <= '0;
        end else if (key_star) begin
          dig_buf <= '1;
          dig_len <= '0;
          case (state)
            S_AUTH: begin
              if (dig_len == LEN_MASTER && dig_buf == MASTER_FULL) begin
                state    <= S_SEL;
                fail_cnt <= '0;
              end else begin
                auth_fail <= 1'b1;
                fail_cnt  <= fail_cnt + 1'b1;
                if (fail_cnt == FAIL_LAST) begin
                  state    <= S_LOCK;
                  lock_cnt <= '0;
                end
              end
            end
            S_NEW: begin
              if (dig_len >= LEN_MIN) begin
                sh_buf <= dig_buf;
                sh_len <= dig_len;
                state  <= S_CONFIRM;
              end else begin
                auth_fail <= 1'b1;
              end
            end
            S_CONFIRM: begin
              if (dig_buf == sh_buf && dig_len == sh_len) begin
                slot_pw       <= dig_buf;
                slot_len      <= dig_len;
                data_setup_ok <= 1'b1;
                state         <= S_IDLE;
              end else begin
                auth_fail <= 1'b1;
                state     <= S_NEW;
              end
            end
            default: ;
          endcase
        end
      end else if (idle_cnt == IDLE_LAST) begin
        state    <= S_IDLE;
        dig_buf  <= '1;
        dig_len  <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  logic [3:0] bcd5, bcd4;
  always_comb begin
    bcd5 = 4'hF;
    case (state)
      S_AUTH:    bcd5 = 4'h0;
      S_SEL:     bcd5 = 4'h1;
      S_NEW:     bcd5 = 4'h2;
      S_CONFIRM: bcd5 = 4'h3;
      S_LOCK:    bcd5 = 4'hE;
      default:   bcd5 = 4'hF;
    endcase
  end

  assign bcd4         = (state == S_NEW || state == S_CONFIRM) ? 4'(slot_idx) : 4'hF;
  assign bcd_pac      = {bcd5, bcd4, dig_buf[15:0]};
  assign setup_active = state != S_IDLE;
  assign display_en   = setup_active;
  assign locked       = state == S_LOCK;
endmodule

// File: tb/tb_setup_multislot.sv
// tb/tb_setup_multislot.sv - directed self-checking bench for setup_multislot
module tb_setup_multislot;
  localparam int LOCK_CYC = 20;
  localparam int IDLE_CYC = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        setup_active, display_en, data_setup_ok, auth_fail, locked;
  logic [23:0] bcd_pac;
  logic [1:0]  slot_idx;
  logic [47:0] slot_pw;
  logic [3:0]  slot_len;
  int          checks = 0;
  int          errors = 0;

  setup_multislot_if kp_if ();

  setup_multislot #(.LOCK_CYC(LOCK_CYC), .IDLE_CYC(IDLE_CYC)) dut (
    .clk(clk), .rst(rst), .kp(kp_if.slave),
    .setup_active(setup_active), .display_en(display_en), .bcd_pac(bcd_pac),
    .slot_idx(slot_idx), .slot_pw(slot_pw), .slot_len(slot_len),
    .data_setup_ok(data_setup_ok), .auth_fail(auth_fail), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    kp_if.key_val   = k;
    kp_if.key_valid = 1'b1;
    tick();
    kp_if.key_valid = 1'b0;
  endtask

  task automatic enter_auth();
    kp_if.setup_req = 1'b0;
    tick();
    kp_if.setup_req = 1'b1;
    tick();
  endtask

  task automatic master_ok();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
  endtask

  initial begin
    int n;
    kp_if.setup_req = 1'b0;
    kp_if.key_val   = 4'h0;
    kp_if.key_valid = 1'b0;
    tick(); tick();
    chk("rst_bcd", bcd_pac, 24'hFFFFFF);
    chk("rst_pw", slot_pw, 48'hFFFF_FFFF_FFFF);
    chk("rst_len", slot_len, 0);
    chk("rst_idx", slot_idx, 0);
    chk("rst_flags", {setup_active, display_en, locked, data_setup_ok, auth_fail}, 0);
    rst = 1'b1;
    tick();

    // T1: wrong master
    enter_auth();
    chk("auth_bcd", bcd_pac, 24'h0FFFFF);
    chk("auth_active", {setup_active, display_en}, 2'b11);
    press(4'h1); press(4'h1); press(4'h1);
    chk("auth_digits", bcd_pac, 24'h0FF111);
    press(4'h1); press(4'hA);
    chk("t1_fail_pulse", auth_fail, 1'b1);
    chk("t1_bcd", bcd_pac, 24'h0FFFFF);
    tick();
    chk("t1_pulse_end", auth_fail, 1'b0);

    // T2: correct master, pick slot 2
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("t2_digits", bcd_pac, 24'h0F1234);
    press(4'hA);
    chk("t2_sel", {setup_active, bcd_pac}, {1'b1, 24'h1FFFFF});
    press(4'h7);
    chk("t2_slot_range", bcd_pac, 24'h1FFFFF);
    press(4'h2);
    chk("t2_new", bcd_pac, 24'h22FFFF);

    // T3/T4: enter 56789, mismatch confirm, then matching confirm
    press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'h9);
    chk("t3_digits", bcd_pac, 24'h226789);
    press(4'hA);
    chk("t3_confirm", bcd_pac, 24'h32FFFF);
    press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'h0); press(4'hA);
    chk("t4_fail", {auth_fail, data_setup_ok}, 2'b10);
    chk("t4_bcd", bcd_pac, 24'h22FFFF);
    chk("t4_nocommit", slot_len, 0);
    press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'h9); press(4'hA);
    press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'h9); press(4'hA);
    chk("t3_ok_pulse", data_setup_ok, 1'b1);
    chk("t3_idx", slot_idx, 2);
    chk("t3_len", slot_len, 5);
    chk("t3_pw", slot_pw, 48'hFFFF_FFF5_6789);
    chk("t3_idle", setup_active, 1'b0);
    tick();
    chk("t3_pulse_end", data_setup_ok, 1'b0);

    // T5: three wrong masters -> lockout
    enter_auth();
    press(4'h9); press(4'hA);
    press(4'h9); press(4'hA);
    chk("t5_not_yet", locked, 1'b0);
    press(4'h9); press(4'hA);
    chk("t5_locked", {locked, auth_fail}, 2'b11);
    chk("t5_bcd", bcd_pac, 24'hEFFFFF);
    n = 0;
    while (locked && n < 200) begin
      n++;
      kp_if.key_val   = 4'($urandom_range(0, 11));
      kp_if.key_valid = 1'b1;
      if (n == 10) chk("t5_keys_ignored", bcd_pac, 24'hEFFFFF);
      tick();
    end
    kp_if.key_valid = 1'b0;
    chk("t5_lock_len", n, LOCK_CYC);
    chk("t5_idle", {setup_active, bcd_pac}, {1'b0, 24'hFFFFFF});
    enter_auth();
    master_ok();
    chk("t5_master_ok", bcd_pac, 24'h1FFFFF);

    // T6: 13 digits into slot 3
    press(4'h3);
    chk("t6_new", bcd_pac, 24'h23FFFF);
    for (int i = 1; i <= 13; i++) press(4'(i % 10));
    chk("t6_digits", bcd_pac, 24'h230123);
    press(4'hA);
    for (int i = 1; i <= 13; i++) press(4'(i % 10));
    press(4'hA);
    chk("t6_commit", {data_setup_ok, slot_idx}, {1'b1, 2'd3});
    chk("t6_len", slot_len, 12);
    chk("t6_pw", slot_pw, 48'h2345_6789_0123);

    // '#' in NEW keeps committed password
    enter_auth();
    master_ok();
    press(4'h1);
    press(4'h4); press(4'h4); press(4'h4); press(4'h4); press(4'hB);
    chk("hash_idle", setup_active, 1'b0);
    chk("hash_pw", {slot_len, slot_pw}, {4'd12, 48'h2345_6789_0123});
    chk("hash_idx", slot_idx, 1);

    // Async reset mid-CONFIRM
    enter_auth();
    master_ok();
    press(4'h0);
    press(4'h5); press(4'h5); press(4'h5); press(4'h5); press(4'hA);
    chk("pre_rst_bcd", bcd_pac, 24'h30FFFF);
    rst = 1'b0;
    #1;
    chk("rst_mid_bcd", bcd_pac, 24'hFFFFFF);
    chk("rst_mid_pw", {slot_len, slot_pw}, {4'd0, 48'hFFFF_FFFF_FFFF});
    chk("rst_mid_flags", {setup_active, slot_idx, locked}, 0);
    tick();
    rst = 1'b1;
    tick();

    // setup_req fall together with confirming '*': abort wins
    enter_auth();
    master_ok();
    press(4'h1);
    press(4'h5); press(4'h5); press(4'h5); press(4'h5); press(4'hA);
    press(4'h5); press(4'h5); press(4'h5); press(4'h5);
    kp_if.setup_req = 1'b0;
    press(4'hA);
    chk("abort_nocommit", {data_setup_ok, slot_len, setup_active}, 0);

    // Idle timeout
    enter_auth();
    repeat (IDLE_CYC - 1) tick();
    chk("timeout_before", setup_active, 1'b1);
    tick();
    chk("timeout_after", setup_active, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
